// File: rtl/grover_measure.sv
// Measurement stage for a Grover search engine: squares the captured amplitudes into a
// running CDF, draws an LFSR-scaled random value below the total and returns the basis index.
module grover_measure #(
  parameter int          NUM_BIT        = 3,
  parameter int          FIXEDPOINT_BIT = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      done_in,
  input  logic [FIXEDPOINT_BIT-1:0] amp0,
  input  logic [FIXEDPOINT_BIT-1:0] amp1,
  input  logic [FIXEDPOINT_BIT-1:0] amp2,
  input  logic [FIXEDPOINT_BIT-1:0] amp3,
  input  logic [FIXEDPOINT_BIT-1:0] amp4,
  input  logic [FIXEDPOINT_BIT-1:0] amp5,
  input  logic [FIXEDPOINT_BIT-1:0] amp6,
  input  logic [FIXEDPOINT_BIT-1:0] amp7,
  input  logic                      meas_ready,
  output logic                      meas_valid,
  output logic [NUM_BIT-1:0]        meas_idx,
  output logic                      err,
  output logic                      busy
);

  localparam int NS     = 2 ** NUM_BIT;
  localparam int SQ_W   = 2 * FIXEDPOINT_BIT;
  localparam int TOT_W  = SQ_W + NUM_BIT;
  localparam int KW     = NUM_BIT + 1;
  localparam int PROD_W = 16 + TOT_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    DRAW   = 3'd2,
    SEARCH = 3'd3,
    VALID  = 3'd4
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Full-width signed square; -2^(W-1) squared still fits without wrapping.
  function automatic logic [SQ_W-1:0] square_amp(input logic signed [FIXEDPOINT_BIT-1:0] a);
    logic signed [SQ_W-1:0] p;
    p = a * a;
    return $unsigned(p);
  endfunction

  state_t                             state_q, state_d;
  logic [15:0]                        lfsr_q, lfsr_d;
  logic signed [FIXEDPOINT_BIT-1:0]   amp_q [NS];
  logic signed [FIXEDPOINT_BIT-1:0]   amp_d [NS];
  logic signed [FIXEDPOINT_BIT-1:0]   amp_in [NS];
  logic [TOT_W-1:0]                   cdf_q [NS];
  logic [TOT_W-1:0]                   cdf_d [NS];
  logic [TOT_W-1:0]                   total_q, total_d;
  logic [TOT_W-1:0]                   r_q, r_d;
  logic [KW-1:0]                      k_q, k_d;
  logic [KW-1:0]                      cnt_q, cnt_d;
  logic                               meas_valid_q, meas_valid_d;
  logic [NUM_BIT-1:0]                 meas_idx_q, meas_idx_d;
  logic                               err_q, err_d;
  logic                               busy_q, busy_d;

  logic [SQ_W-1:0]                    sq;
  logic [TOT_W-1:0]                   sum;
  logic [PROD_W-1:0]                  prod;
  logic                               hit;

  assign amp_in[0] = amp0;
  assign amp_in[1] = amp1;
  assign amp_in[2] = amp2;
  assign amp_in[3] = amp3;
  assign amp_in[4] = amp4;
  assign amp_in[5] = amp5;
  assign amp_in[6] = amp6;
  assign amp_in[7] = amp7;

  assign meas_valid = meas_valid_q;
  assign meas_idx   = meas_idx_q;
  assign err        = err_q;
  assign busy       = busy_q;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_step(lfsr_q);
    total_d      = total_q;
    r_d          = r_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    meas_valid_d = meas_valid_q;
    meas_idx_d   = meas_idx_q;
    err_d        = err_q;
    busy_d       = busy_q;
    for (int i = 0; i < NS; i++) begin
      amp_d[i] = amp_q[i];
      cdf_d[i] = cdf_q[i];
    end

    sq   = square_amp(amp_q[k_q[NUM_BIT-1:0]]);
    sum  = total_q + TOT_W'(sq);
    prod = PROD_W'(lfsr_q) * PROD_W'(total_q);
    hit  = (cdf_q[k_q[NUM_BIT-1:0]] <= r_q);

    case (state_q)
      IDLE: begin
        if (start && done_in) begin
          for (int i = 0; i < NS; i++) begin
            amp_d[i] = amp_in[i];
          end
          total_d = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = SQUARE;
        end
      end

      SQUARE: begin
        total_d                    = sum;
        cdf_d[k_q[NUM_BIT-1:0]]    = sum;
        k_d                        = k_q + 1'b1;
        if (k_q == KW'(NS - 1)) begin
          state_d = DRAW;
        end
      end

      // lfsr/2^16 scaled by total keeps r strictly below total whenever total is nonzero.
      DRAW: begin
        r_d     = prod[PROD_W-1:16];
        k_d     = '0;
        cnt_d   = '0;
        state_d = SEARCH;
      end

      // Eight compare cycles; the following cycle folds the count into the result.
      SEARCH: begin
        if (k_q == KW'(NS)) begin
          if (total_q == '0) begin
            meas_idx_d = '0;
            err_d      = 1'b1;
          end else begin
            meas_idx_d = (cnt_q > KW'(NS - 1)) ? '1 : cnt_q[NUM_BIT-1:0];
            err_d      = 1'b0;
          end
          meas_valid_d = 1'b1;
          state_d      = VALID;
        end else begin
          if (hit) begin
            cnt_d = cnt_q + 1'b1;
          end
          k_d = k_q + 1'b1;
        end
      end

      VALID: begin
        if (meas_ready) begin
          meas_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      total_q      <= '0;
      r_q          <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      meas_valid_q <= 1'b0;
      meas_idx_q   <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        amp_q[i] <= '0;
        cdf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      total_q      <= total_d;
      r_q          <= r_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      meas_valid_q <= meas_valid_d;
      meas_idx_q   <= meas_idx_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      for (int i = 0; i < NS; i++) begin
        amp_q[i] <= amp_d[i];
        cdf_q[i] <= cdf_d[i];
      end
    end
  end

endmodule

// File: doc/grover_measure.md
GROVER_MEASURE -- requirements
Module: grover_measure

Interface
REQ-001 SHALL have parameter NUM_BIT, default 3, meaning qubit count; NUM_SAMPLE = 2**NUM_BIT = 8 amplitudes.
REQ-002 SHALL have parameter FIXEDPOINT_BIT, default 8, meaning signed amplitude width.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero LFSR reset value.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL provide these ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request for a measurement.
- done_in  in  1  amplitudes are valid and stable (the Grover engine's done).
- amp0..amp7  in  FIXEDPOINT_BIT each  signed amplitudes.
- meas_ready  in  1  consumer accepts the result.
- meas_valid  out  1  result is available.
- meas_idx  out  NUM_BIT  measured basis index.
- err  out  1  all amplitudes were zero; qualified by meas_valid.
- busy  out  1  a measurement is in progress.

Function
REQ-006 SHALL advance a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) every clock cycle in all states.
REQ-007 SHALL implement the states IDLE, SQUARE, DRAW, SEARCH and VALID.
REQ-008 IDLE: if start=1 and done_in=1, SHALL capture amp0..amp7 into internal registers, clear the accumulator, and go to SQUARE; start without done_in SHALL be ignored.
REQ-009 SQUARE: for 8 cycles, index k=0..7, SHALL compute p[k]=amp[k]*amp[k] as a 16-bit unsigned value, update total+=p[k] (19-bit), and store cdf[k]=total; then go to DRAW.
REQ-010 DRAW: for one cycle, SHALL compute r=(lfsr*total)>>16 with a 35-bit product, giving 0<=r<total when total>0; then go to SEARCH.
REQ-011 SEARCH: for exactly 8 cycles, SHALL count entries with cdf[k]<=r and set meas_idx=min(count,7), i.e. the first k with r<cdf[k]; then go to VALID.
REQ-012 If total==0 at DRAW, SHALL still run SEARCH, then present meas_idx=0 with err=1.
REQ-013 VALID: SHALL hold meas_valid=1 with meas_idx and err stable until meas_ready=1 on a rising edge; it SHALL then return to IDLE with meas_valid=0 on the next cycle.
REQ-014 meas_valid SHALL assert exactly 18 cycles after the edge that accepts start, and meas_ready SHALL never be required before meas_valid.
REQ-015 busy SHALL be 1 in SQUARE, DRAW, SEARCH and VALID, and 0 in IDLE.
REQ-016 start while busy=1 SHALL be ignored; a start in the same cycle as the meas_ready handshake SHALL be ignored.
REQ-017 Changes on amp0..amp7 or done_in after capture SHALL not affect the result in progress.
REQ-018 Amplitude -128 SHALL square to 16384 with no overflow; 8*16384 SHALL fit in total.

Reset
REQ-019 While rst=0: state=IDLE, meas_valid=0, meas_idx=0, err=0, busy=0, lfsr=LFSR_SEED, and all accumulators and captured amplitudes=0.
REQ-020 Reset asserted mid-operation SHALL abort immediately with no result; after release the block SHALL accept a new start normally.

Verification
REQ-021 Single target: amp5=64, others 0, start with done_in=1, meas_ready=1 -> meas_valid at cycle +18, meas_idx=5, err=0, for 100 repeats.
REQ-022 Uniform: all amps=22 (total 3872), 8000 measurements -> each index 1000+/-150, and each result matches the reference model r=(lfsr*3872)>>16 using the LFSR state from the DRAW cycle.
REQ-023 All amps 0 -> meas_valid at +18, meas_idx=0, err=1.
REQ-024 Backpressure: meas_ready=0 for 10 cycles after meas_valid -> meas_valid and meas_idx held stable; meas_ready=1 -> busy=0 on the next cycle; start pulses while busy, and start with done_in=0, produce no extra result.
REQ-025 Reset: rst=0 during SEARCH -> meas_valid=0 and busy=0 at once, lfsr=16'hACE1; a new start after release gives the expected result at +18.
REQ-026 Extreme: amp0=-128, amp7=127, others 0 -> meas_idx is only 0 or 7, and the share of 0 is ~16384/32513.
